// File: rtl/sva_chk_pkg.sv
// Shared types and helpers for the range-delay checker (ant |-> ##[MIN_DLY:MAX_DLY] cons).
package sva_chk_pkg;

    localparam int MAX_DLY_LIMIT = 31;
    localparam int CHK_CNT_W     = 16;

    typedef logic [CHK_CNT_W-1:0] chk_cnt_t;

    typedef enum logic [1:0] {
        RES_NONE = 2'd0,
        RES_PASS = 2'd1,
        RES_FAIL = 2'd2,
        RES_BOTH = 2'd3
    } chk_res_e;

    // Add at one extra bit, then clamp to all-ones so the counter never wraps.
    function automatic chk_cnt_t sat_add(input chk_cnt_t a, input chk_cnt_t b);
        logic [CHK_CNT_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[CHK_CNT_W] ? '1 : sum[CHK_CNT_W-1:0];
    endfunction

endpackage

// File: rtl/sva_chk_popcount.sv
// Combinational popcount of the per-age pass and fail masks for one sample.
module sva_chk_popcount
    import sva_chk_pkg::*;
#(
    parameter int W  = 4,
    parameter int CW = $clog2(W + 1)
) (
    input  logic [W-1:0]  pass_mask,
    input  logic [W-1:0]  fail_mask,
    output logic [CW-1:0] npass,
    output logic [CW-1:0] nfail
);

    always_comb begin
        npass = '0;
        nfail = '0;
        for (int i = 0; i < W; i++) begin
            npass = npass + CW'(pass_mask[i]);
            nfail = nfail + CW'(fail_mask[i]);
        end
    end

endmodule

// File: rtl/sva_range_delay_checker.sv
// Synthesizable checker for ant |-> ##[MIN_DLY:MAX_DLY] cons with saturating counters.
// Optional first-fail timestamp capture is enabled by defining SVA_CHK_FIRST_FAIL_EN.
module sva_range_delay_checker
    import sva_chk_pkg::*;
#(
    parameter int MIN_DLY = 1,
    parameter int MAX_DLY = 3,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic             ant,
    input  logic             cons,
    output logic             pass_pulse,
    output logic             fail_pulse,
    output logic             pending,
    output logic [CNT_W-1:0] check_count,
`ifdef SVA_CHK_FIRST_FAIL_EN
    output logic [CNT_W-1:0] pass_count,
    output logic             first_fail_vld,
    output logic [CNT_W-1:0] first_fail_cyc
`else
    output logic [CNT_W-1:0] pass_count
`endif
);

    localparam int W  = MAX_DLY + 1;
    localparam int CW = $clog2(MAX_DLY + 2);
    // Sum width covers both the counter and a full-window burst of resolutions.
    localparam int AW = ((CNT_W > CW) ? CNT_W : CW) + 2;
    localparam logic [AW-1:0] CNT_MAX = AW'({CNT_W{1'b1}});

    if (MAX_DLY > MAX_DLY_LIMIT || MAX_DLY < MIN_DLY || MIN_DLY < 0) begin : g_bad_cfg
        $error("sva_range_delay_checker: illegal MIN_DLY/MAX_DLY");
    end

    logic [W-1:0]  act_q;
    logic [W-1:0]  act_d;
    logic [W-1:0]  cur;
    logic [W-1:0]  pass_mask;
    logic [W-1:0]  fail_mask;
    logic [CW-1:0] npass;
    logic [CW-1:0] nfail;
    logic [AW-1:0] chk_sum;
    logic [AW-1:0] pass_sum;
    logic          start;

    // Bit 0 of act_q is always cleared by the shift; the new attempt enters through start.
    always_comb begin
        start     = en & ant;
        cur       = '0;
        pass_mask = '0;
        fail_mask = '0;
        act_d     = '0;
        for (int k = 0; k < W; k++) begin
            cur[k]       = act_q[k] | ((k == 0) & start);
            pass_mask[k] = cur[k] & cons & (k >= MIN_DLY);
            fail_mask[k] = cur[k] & ~pass_mask[k] & (k == MAX_DLY);
        end
        for (int k = 1; k < W; k++) begin
            act_d[k] = cur[k-1] & ~pass_mask[k-1] & ~fail_mask[k-1];
        end
    end

    sva_chk_popcount #(
        .W  (W),
        .CW (CW)
    ) u_popcount (
        .pass_mask (pass_mask),
        .fail_mask (fail_mask),
        .npass     (npass),
        .nfail     (nfail)
    );

    always_comb begin
        chk_sum  = AW'(check_count) + AW'(npass) + AW'(nfail);
        pass_sum = AW'(pass_count) + AW'(npass);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_q       <= '0;
            pass_pulse  <= 1'b0;
            fail_pulse  <= 1'b0;
            check_count <= '0;
            pass_count  <= '0;
        end else if (clr) begin
            act_q       <= '0;
            pass_pulse  <= 1'b0;
            fail_pulse  <= 1'b0;
            check_count <= '0;
            pass_count  <= '0;
        end else begin
            act_q       <= act_d;
            pass_pulse  <= (npass != '0);
            fail_pulse  <= (nfail != '0);
            check_count <= (chk_sum > CNT_MAX) ? {CNT_W{1'b1}} : chk_sum[CNT_W-1:0];
            pass_count  <= (pass_sum > CNT_MAX) ? {CNT_W{1'b1}} : pass_sum[CNT_W-1:0];
        end
    end

    assign pending = |act_q;

`ifdef SVA_CHK_FIRST_FAIL_EN
    logic [CNT_W-1:0] cyc_q;

    // Free-running timestamp; only reset clears it, clr leaves it running.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_q <= '0;
        end else begin
            cyc_q <= cyc_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            first_fail_vld <= 1'b0;
            first_fail_cyc <= '0;
        end else if (clr) begin
            first_fail_vld <= 1'b0;
            first_fail_cyc <= '0;
        end else if (!first_fail_vld && nfail != '0) begin
            first_fail_vld <= 1'b1;
            first_fail_cyc <= cyc_q;
        end
    end
`endif

endmodule

// File: tb/tb_sva_range_delay_checker.sv
// Randomized and directed bench for sva_range_delay_checker over four parameter sets.
module tb_sva_range_delay_checker;
    import sva_chk_pkg::*;

    logic clk;
    logic rst_n;
    logic clr;
    logic en;
    logic ant;
    logic cons;

    logic        pp_o   [4];
    logic        fp_o   [4];
    logic        pend_o [4];
    logic [15:0] cc_o   [3];
    logic [15:0] pc_o   [3];
    logic [1:0]  cc_sat;
    logic [1:0]  pc_sat;

    int checks;
    int errors;
    int both_cnt;
    int t;

    // Instance parameters: 0 = defaults, 1 = MIN 2, 2 = zero window, 3 = 2-bit counters.
    int min_c [4] = '{1, 2, 0, 1};
    int max_c [4] = '{3, 3, 0, 3};
    int lim_c [4] = '{65535, 65535, 65535, 3};

    int st_q   [4][$];
    int chk_m  [4];
    int pass_m [4];
    bit pp_m   [4];
    bit fp_m   [4];

`ifdef SVA_CHK_FIRST_FAIL_EN
    logic        ffv_o [4];
    logic [15:0] ffc_o [3];
    logic [1:0]  ffc_sat;
`endif

    sva_range_delay_checker #(.MIN_DLY(1), .MAX_DLY(3), .CNT_W(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .en(en), .ant(ant), .cons(cons),
        .pass_pulse(pp_o[0]), .fail_pulse(fp_o[0]), .pending(pend_o[0]),
`ifdef SVA_CHK_FIRST_FAIL_EN
        .first_fail_vld(ffv_o[0]), .first_fail_cyc(ffc_o[0]),
`endif
        .check_count(cc_o[0]), .pass_count(pc_o[0])
    );

    sva_range_delay_checker #(.MIN_DLY(2), .MAX_DLY(3), .CNT_W(16)) u_min2 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .en(en), .ant(ant), .cons(cons),
        .pass_pulse(pp_o[1]), .fail_pulse(fp_o[1]), .pending(pend_o[1]),
`ifdef SVA_CHK_FIRST_FAIL_EN
        .first_fail_vld(ffv_o[1]), .first_fail_cyc(ffc_o[1]),
`endif
        .check_count(cc_o[1]), .pass_count(pc_o[1])
    );

    sva_range_delay_checker #(.MIN_DLY(0), .MAX_DLY(0), .CNT_W(16)) u_zero (
        .clk(clk), .rst_n(rst_n), .clr(clr), .en(en), .ant(ant), .cons(cons),
        .pass_pulse(pp_o[2]), .fail_pulse(fp_o[2]), .pending(pend_o[2]),
`ifdef SVA_CHK_FIRST_FAIL_EN
        .first_fail_vld(ffv_o[2]), .first_fail_cyc(ffc_o[2]),
`endif
        .check_count(cc_o[2]), .pass_count(pc_o[2])
    );

    sva_range_delay_checker #(.MIN_DLY(1), .MAX_DLY(3), .CNT_W(2)) u_sat (
        .clk(clk), .rst_n(rst_n), .clr(clr), .en(en), .ant(ant), .cons(cons),
        .pass_pulse(pp_o[3]), .fail_pulse(fp_o[3]), .pending(pend_o[3]),
`ifdef SVA_CHK_FIRST_FAIL_EN
        .first_fail_vld(ffv_o[3]), .first_fail_cyc(ffc_sat),
`endif
        .check_count(cc_sat), .pass_count(pc_sat)
    );

    // Clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0d)", tag, obs, exp, t);
        end
    endtask

    function automatic logic [31:0] cc_of(input int c);
        return (c == 3) ? {30'b0, cc_sat} : {16'b0, cc_o[c]};
    endfunction

    function automatic logic [31:0] pc_of(input int c);
        return (c == 3) ? {30'b0, pc_sat} : {16'b0, pc_o[c]};
    endfunction

    // Reference model: each attempt is kept as its start timestamp; its age is t - start.
    task automatic model_clear();
        for (int c = 0; c < 4; c++) begin
            st_q[c].delete();
            chk_m[c]  = 0;
            pass_m[c] = 0;
            pp_m[c]   = 1'b0;
            fp_m[c]   = 1'b0;
        end
    endtask

    task automatic model_sample(input bit a, input bit c_in, input bit e, input bit k);
        int keep[$];
        int np;
        int nf;
        int age;
        if (k) begin
            model_clear();
            return;
        end
        for (int c = 0; c < 4; c++) begin
            if (e && a) st_q[c].push_back(t);
            keep = {};
            np = 0;
            nf = 0;
            foreach (st_q[c][i]) begin
                age = t - st_q[c][i];
                if (age >= min_c[c] && age <= max_c[c] && c_in) np++;
                else if (age >= max_c[c]) nf++;
                else keep.push_back(st_q[c][i]);
            end
            st_q[c]   = keep;
            pp_m[c]   = (np != 0);
            fp_m[c]   = (nf != 0);
            chk_m[c]  = (chk_m[c] + np + nf > lim_c[c]) ? lim_c[c] : chk_m[c] + np + nf;
            pass_m[c] = (pass_m[c] + np > lim_c[c]) ? lim_c[c] : pass_m[c] + np;
            if (c == 0) begin
                chk_res_e r;
                r = chk_res_e'({nf != 0, np != 0});
                if (r == RES_BOTH) both_cnt++;
            end
        end
    endtask

    task automatic compare_all();
        for (int c = 0; c < 4; c++) begin
            check($sformatf("pass_pulse[%0d]", c), {31'b0, pp_o[c]}, {31'b0, pp_m[c]});
            check($sformatf("fail_pulse[%0d]", c), {31'b0, fp_o[c]}, {31'b0, fp_m[c]});
            check($sformatf("pending[%0d]", c), {31'b0, pend_o[c]}, {31'b0, st_q[c].size() != 0});
            check($sformatf("check_count[%0d]", c), cc_of(c), chk_m[c]);
            check($sformatf("pass_count[%0d]", c), pc_of(c), pass_m[c]);
        end
    endtask

    // Driver: apply one sample, let the edge happen, update the model, compare.
    task automatic step(input bit a, input bit c_in, input bit e, input bit k);
        ant  = a;
        cons = c_in;
        en   = e;
        clr  = k;
        @(posedge clk);
        t++;
        model_sample(a, c_in, e, k);
        #1;
        compare_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        both_cnt = 0;
        t        = 0;
        rst_n    = 1'b0;
        clr      = 1'b0;
        en       = 1'b0;
        ant      = 1'b0;
        cons     = 1'b0;
        model_clear();
        #12;
        compare_all();
        @(negedge clk);
        rst_n = 1'b1;

        // Single attempt, cons at age 3
        step(1, 0, 1, 1);
        step(1, 0, 1, 0);
        idle(2);
        step(0, 1, 1, 0);
        check("tp1_check_count", cc_of(0), 1);
        check("tp1_pass_count", pc_of(0), 1);
        check("tp1_pass_pulse", {31'b0, pp_o[0]}, 1);

        // Single attempt, never satisfied
        step(0, 0, 1, 1);
        step(1, 0, 1, 0);
        idle(3);
        check("tp2_fail_pulse", {31'b0, fp_o[0]}, 1);
        check("tp2_check_count", cc_of(0), 1);
        check("tp2_pass_count", pc_of(0), 0);
        check("tp2_pending", {31'b0, pend_o[0]}, 0);

        // Three overlapping attempts passed by one cons
        step(0, 0, 1, 1);
        step(1, 0, 1, 0);
        step(1, 0, 1, 0);
        step(1, 0, 1, 0);
        step(0, 1, 1, 0);
        check("tp3_pass_count", pc_of(0), 3);
        idle(4);
        check("tp3_pass_count_hold", pc_of(0), 3);

        // MIN_DLY=2 ignores cons at age 1
        step(0, 0, 1, 1);
        step(1, 0, 1, 0);
        step(0, 1, 1, 0);
        idle(3);
        check("tp4_check_count", cc_of(1), 1);
        check("tp4_pass_count", pc_of(1), 0);

        // Zero-width window, plus 2-bit saturation
        step(0, 0, 1, 1);
        for (int i = 0; i < 5; i++) step(1, 1, 1, 0);
        check("tp5_zero_pass", pc_of(2), 5);
        check("tp5_sat_pass", pc_of(3), 3);
        step(1, 0, 1, 0);
        check("tp5_zero_fail", {31'b0, fp_o[2]}, 1);
        check("tp5_zero_check", cc_of(2), 6);
        check("tp5_zero_pending", {31'b0, pend_o[2]}, 0);
        idle(4);

        // en low stops starts only
        step(0, 0, 1, 1);
        step(1, 0, 1, 0);
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        check("en_low_check", cc_of(0), 1);

        // Asynchronous reset mid-window
        step(0, 0, 1, 1);
        step(1, 0, 1, 0);
        step(1, 0, 1, 0);
        #3;
        rst_n = 1'b0;
        #1;
        model_clear();
        check("rst_pending", {31'b0, pend_o[0]}, 0);
        check("rst_check_count", cc_of(0), 0);
        compare_all();
        #2;
        rst_n = 1'b1;
        idle(5);
        check("post_rst_count", cc_of(0), 0);

        // Randomized
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 99) < 45), ($urandom_range(0, 99) < 30),
                 ($urandom_range(0, 99) < 85), ($urandom_range(0, 99) < 2));
        end

        $display("info: samples with simultaneous pass and fail on default instance: %0d", both_cnt);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
